// File: rtl/bexkat1_wb_arb.sv
// Two-master Wishbone pipelined arbiter: data master has fixed priority.
// The grant holds until the owner releases cyc and every accepted strobe is acked.
module bexkat1_wb_arb #(
    parameter int MAX_OUT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ins_cyc_i,
    input  logic        ins_stb_i,
    input  logic        ins_we_i,
    input  logic [31:0] ins_adr_i,
    input  logic [3:0]  ins_sel_i,
    input  logic [31:0] ins_dat_i,
    output logic        ins_ack_o,
    output logic        ins_stall_o,
    output logic [31:0] ins_dat_o,
    input  logic        dat_cyc_i,
    input  logic        dat_stb_i,
    input  logic        dat_we_i,
    input  logic [31:0] dat_adr_i,
    input  logic [3:0]  dat_sel_i,
    input  logic [31:0] dat_dat_i,
    output logic        dat_ack_o,
    output logic        dat_stall_o,
    output logic [31:0] dat_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic        s_stall_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  owner
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] FULL = CW'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INS  = 2'd1,
        DAT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_out;
    logic          w_busy;
    logic          w_full;
    logic          w_inc;
    logic          w_dec;

    assign w_busy = (r_out != '0);
    assign w_full = (r_out == FULL);
    assign owner  = r_state;

    // Read data is broadcast; only the ack qualifies it.
    assign ins_dat_o = s_dat_i;
    assign dat_dat_o = s_dat_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        s_cyc_o     = 1'b0;
        s_stb_o     = 1'b0;
        s_we_o      = 1'b0;
        s_adr_o     = '0;
        s_sel_o     = '0;
        s_dat_o     = '0;
        ins_ack_o   = 1'b0;
        dat_ack_o   = 1'b0;
        ins_stall_o = 1'b1;
        dat_stall_o = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (dat_cyc_i) begin
                    w_next = DAT;
                end else if (ins_cyc_i) begin
                    w_next = INS;
                end
            end
            INS: begin
                // Keep the bus cycle open until late acks drain.
                s_cyc_o     = ins_cyc_i | w_busy;
                s_stb_o     = ins_cyc_i & ins_stb_i & ~w_full;
                s_we_o      = ins_we_i;
                s_adr_o     = ins_adr_i;
                s_sel_o     = ins_sel_i;
                s_dat_o     = ins_dat_i;
                ins_stall_o = s_stall_i | w_full;
                ins_ack_o   = s_ack_i;
                if (!ins_cyc_i && !w_busy) begin
                    w_next = IDLE;
                end
            end
            DAT: begin
                s_cyc_o     = dat_cyc_i | w_busy;
                s_stb_o     = dat_cyc_i & dat_stb_i & ~w_full;
                s_we_o      = dat_we_i;
                s_adr_o     = dat_adr_i;
                s_sel_o     = dat_sel_i;
                s_dat_o     = dat_dat_i;
                dat_stall_o = s_stall_i | w_full;
                dat_ack_o   = s_ack_i;
                if (!dat_cyc_i && !w_busy) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_inc = s_cyc_o & s_stb_o & ~s_stall_i;
    assign w_dec = s_ack_i & w_busy;

    // Stray acks at zero outstanding are dropped so the count cannot wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out <= '0;
        end else if (w_inc && !w_dec) begin
            r_out <= r_out + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_out <= r_out - 1'b1;
        end
    end

endmodule

// File: tb/tb_bexkat1_wb_arb.sv
// Directed bench for bexkat1_wb_arb: vector table plus
// hand-written release, reset and stall sequences.
module tb_bexkat1_wb_arb;

    logic        clk;
    logic        rst;
    logic        ins_cyc, ins_stb, dat_cyc, dat_stb;
    logic        s_ack, s_stall;
    logic        ins_ack, ins_stall, dat_ack, dat_stall;
    logic [31:0] ins_dato, dat_dato;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic [1:0]  owner;

    int nchk = 0;
    int nerr = 0;

    bexkat1_wb_arb #(.MAX_OUT(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ins_cyc_i   (ins_cyc),
        .ins_stb_i   (ins_stb),
        .ins_we_i    (1'b0),
        .ins_adr_i   (32'h0000_0100),
        .ins_sel_i   (4'h3),
        .ins_dat_i   (32'h1111_1111),
        .ins_ack_o   (ins_ack),
        .ins_stall_o (ins_stall),
        .ins_dat_o   (ins_dato),
        .dat_cyc_i   (dat_cyc),
        .dat_stb_i   (dat_stb),
        .dat_we_i    (1'b1),
        .dat_adr_i   (32'h0000_0200),
        .dat_sel_i   (4'hC),
        .dat_dat_i   (32'h2222_2222),
        .dat_ack_o   (dat_ack),
        .dat_stall_o (dat_stall),
        .dat_dat_o   (dat_dato),
        .s_cyc_o     (s_cyc),
        .s_stb_o     (s_stb),
        .s_we_o      (s_we),
        .s_adr_o     (s_adr),
        .s_sel_o     (s_sel),
        .s_dat_o     (s_dat),
        .s_ack_i     (s_ack),
        .s_stall_i   (s_stall),
        .s_dat_i     (32'hDEAD_BEEF),
        .owner       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, icyc, istb, dcyc, dstb, sack;
        logic [1:0] own;
        logic       scyc, sstb, iack, dack, ist, dst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, ic, is, dc, ds, sa,
        input logic [1:0] o,
        input logic sc, sb, ia, da, ist, dst);
        vec_t v;
        v.rst = r; v.icyc = ic; v.istb = is;
        v.dcyc = dc; v.dstb = ds; v.sack = sa;
        v.own = o; v.scyc = sc; v.sstb = sb;
        v.iack = ia; v.dack = da; v.ist = ist; v.dst = dst;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic drv(input logic r, ic, is, dc, ds, sa, st);
        @(negedge clk);
        rst = r; ins_cyc = ic; ins_stb = is;
        dat_cyc = dc; dat_stb = ds; s_ack = sa; s_stall = st;
        #2;
    endtask

    initial begin
        logic [31:0] eadr, edat;
        logic [3:0]  esel;
        logic        ewe;
        rst = 1'b1; ins_cyc = 0; ins_stb = 0;
        dat_cyc = 0; dat_stb = 0; s_ack = 0; s_stall = 0;
        repeat (3) @(posedge clk);

        //           rst ic is dc ds sa  own sc sb ia da ist dst
        tbl.push_back(mk(1,0,0,0,0,0, 0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,1,1,0,0,0, 0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,0,0,0,1, 1, 1,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0, 1, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,1,1,1,1,0, 0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,1,1,1,1,0, 2, 1,1,0,0,1,0));
        tbl.push_back(mk(0,1,1,1,0,0, 2, 1,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,0,0,1, 2, 1,0,0,1,1,0));
        tbl.push_back(mk(0,1,1,0,0,0, 2, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,0,0,0, 0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,0,0,0,1,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,0,0,0,1,1));
        tbl.push_back(mk(0,1,1,0,0,1, 1, 1,0,1,0,1,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,0,0,0,1,1));
        tbl.push_back(mk(0,1,0,0,0,1, 1, 1,0,1,0,1,1));
        tbl.push_back(mk(0,1,0,0,0,1, 1, 1,0,1,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,1, 1, 1,1,1,0,0,1));
        tbl.push_back(mk(0,1,0,0,0,0, 1, 1,0,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 1, 1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,1,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0, 1, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 0, 0,0,0,0,1,1));

        foreach (tbl[i]) begin
            drv(tbl[i].rst, tbl[i].icyc, tbl[i].istb,
                tbl[i].dcyc, tbl[i].dstb, tbl[i].sack, 1'b0);
            case (tbl[i].own)
                2'd1: begin
                    eadr = 32'h100; esel = 4'h3;
                    edat = 32'h1111_1111; ewe = 1'b0;
                end
                2'd2: begin
                    eadr = 32'h200; esel = 4'hC;
                    edat = 32'h2222_2222; ewe = 1'b1;
                end
                default: begin
                    eadr = '0; esel = '0; edat = '0; ewe = 1'b0;
                end
            endcase
            chk($sformatf("r%0d owner", i), 32'(owner), 32'(tbl[i].own));
            chk($sformatf("r%0d s_cyc", i), 32'(s_cyc), 32'(tbl[i].scyc));
            chk($sformatf("r%0d s_stb", i), 32'(s_stb), 32'(tbl[i].sstb));
            chk($sformatf("r%0d ins_ack", i), 32'(ins_ack), 32'(tbl[i].iack));
            chk($sformatf("r%0d dat_ack", i), 32'(dat_ack), 32'(tbl[i].dack));
            chk($sformatf("r%0d ins_stall", i), 32'(ins_stall), 32'(tbl[i].ist));
            chk($sformatf("r%0d dat_stall", i), 32'(dat_stall), 32'(tbl[i].dst));
            chk($sformatf("r%0d s_adr", i), s_adr, eadr);
            chk($sformatf("r%0d s_sel", i), 32'(s_sel), 32'(esel));
            chk($sformatf("r%0d s_dat", i), s_dat, edat);
            chk($sformatf("r%0d s_we", i), 32'(s_we), 32'(ewe));
        end

        // data owner drops cyc with two outstanding while ins waits
        drv(0,1,1,1,1,0,0); chk("rel idle", 32'(owner), 32'd0);
        drv(0,1,1,1,1,0,0); chk("rel own2", 32'(owner), 32'd2);
        chk("rel stb a", 32'(s_stb), 32'd1);
        drv(0,1,1,1,1,0,0); chk("rel stb b", 32'(s_stb), 32'd1);
        drv(0,1,1,0,0,0,0); chk("rel cyc hold", 32'(s_cyc), 32'd1);
        chk("rel stb0", 32'(s_stb), 32'd0);
        chk("rel own hold", 32'(owner), 32'd2);
        drv(0,1,1,0,0,1,0); chk("rel dack1", 32'(dat_ack), 32'd1);
        chk("rel iack1", 32'(ins_ack), 32'd0);
        chk("rel dat data", dat_dato, 32'hDEAD_BEEF);
        drv(0,1,1,0,0,1,0); chk("rel dack2", 32'(dat_ack), 32'd1);
        chk("rel cyc last", 32'(s_cyc), 32'd1);
        drv(0,1,1,0,0,0,0); chk("rel drained", 32'(s_cyc), 32'd0);
        chk("rel own still2", 32'(owner), 32'd2);
        drv(0,1,1,0,0,0,0); chk("rel gap", 32'(owner), 32'd0);
        drv(0,1,1,0,0,0,0); chk("rel own1", 32'(owner), 32'd1);
        chk("rel ins stb", 32'(s_stb), 32'd1);
        drv(0,1,1,0,0,0,0); chk("pre rst stb2", 32'(s_stb), 32'd1);
        drv(0,1,1,0,0,0,0); chk("pre rst stb3", 32'(s_stb), 32'd1);

        // reset mid-burst with three outstanding
        drv(1,1,1,0,0,0,0); chk("rst own before", 32'(owner), 32'd1);
        drv(1,1,1,0,0,1,0);
        chk("rst owner", 32'(owner), 32'd0);
        chk("rst s_cyc", 32'(s_cyc), 32'd0);
        chk("rst s_stb", 32'(s_stb), 32'd0);
        chk("rst ins_stall", 32'(ins_stall), 32'd1);
        chk("rst dat_stall", 32'(dat_stall), 32'd1);
        chk("rst ins_ack", 32'(ins_ack), 32'd0);
        chk("rst dat_ack", 32'(dat_ack), 32'd0);
        drv(0,1,1,0,0,0,0); chk("post rst idle", 32'(owner), 32'd0);

        // slave stall passes through and accepts nothing
        drv(0,1,1,0,0,0,1); chk("stall own", 32'(owner), 32'd1);
        chk("stall ins", 32'(ins_stall), 32'd1);
        chk("stall dat", 32'(dat_stall), 32'd1);
        chk("ins data", ins_dato, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            drv(0,1,1,0,0,0,0);
            chk($sformatf("fill %0d stall", k), 32'(ins_stall), 32'd0);
            chk($sformatf("fill %0d stb", k), 32'(s_stb), 32'd1);
        end
        drv(0,1,1,0,0,0,0); chk("fill full stall", 32'(ins_stall), 32'd1);
        chk("fill full stb", 32'(s_stb), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/bexkat1_wb_arb.md
BEXKAT1_WB_ARB -- requirements
Module: bexkat1_wb_arb

Interface
REQ-001 Parameter MAX_OUT, default 4: maximum outstanding pipelined requests per grant (matches fetch REQ_MAX).
REQ-002 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 ins_cyc_i, ins_stb_i, ins_we_i  input  1 each  instruction-master cycle, strobe and write enable.
REQ-005 ins_adr_i  input  32; ins_sel_i  input  4; ins_dat_i  input  32  instruction-master address, byte selects and write data.
REQ-006 ins_ack_o, ins_stall_o  output  1 each; ins_dat_o  output  32  instruction-master acknowledge, stall and read data.
REQ-007 dat_cyc_i, dat_stb_i, dat_we_i, dat_adr_i[32], dat_sel_i[4], dat_dat_i[32]  input  data-master request signals, same meaning as REQ-004/005.
REQ-008 dat_ack_o, dat_stall_o  output  1 each; dat_dat_o  output  32  data-master response signals.
REQ-009 s_cyc_o, s_stb_o, s_we_o  output  1 each; s_adr_o  output  32; s_sel_o  output  4; s_dat_o  output  32  shared slave-side request.
REQ-010 s_ack_i, s_stall_i  input  1 each; s_dat_i  input  32  shared slave-side response.
REQ-011 owner  output  2  current grant: 0 = none, 1 = ins, 2 = dat.

Function
REQ-012 The state machine SHALL have states IDLE, INS and DAT; owner SHALL encode the state as in REQ-011.
REQ-013 In IDLE, dat_cyc_i high SHALL move to DAT next cycle; otherwise ins_cyc_i high SHALL move to INS; otherwise remain IDLE. Data has fixed priority.
REQ-014 While in INS or DAT, the grant SHALL be held until the owner's cyc is low and outstanding == 0; then return to IDLE. There is no direct INS->DAT transition.
REQ-015 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and both stall outputs SHALL be 1.
REQ-016 When granted, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o and s_dat_o SHALL be combinational copies of the owner's inputs, with s_stb_o gated by the outstanding limit (REQ-018).
REQ-017 When granted, owner stall SHALL equal s_stall_i OR (outstanding == MAX_OUT), and non-owner stall SHALL be 1.
REQ-018 Outstanding counter, width clog2(MAX_OUT+1):
  - +1 on s_cyc_o & s_stb_o & !s_stall_i;
  - -1 on s_ack_i;
  - unchanged when both occur in the same cycle.
  - While outstanding == MAX_OUT, s_stb_o SHALL be forced low.
REQ-019 s_ack_i SHALL route only to the owner's ack; the non-owner ack SHALL be 0.
REQ-020 s_dat_i SHALL drive both ins_dat_o and dat_dat_o unconditionally.
REQ-021 s_ack_i with outstanding == 0 SHALL be ignored (counter does not underflow) and routed per REQ-019.
REQ-022 If the owner drops cyc while outstanding > 0:
  - s_cyc_o SHALL stay high until outstanding == 0;
  - s_stb_o SHALL be 0;
  - acks SHALL still route to that owner.

Reset
REQ-023 On rst_i high at a clock edge:
  - state SHALL become IDLE and outstanding SHALL become 0;
  - owner SHALL be 0;
  - all acks, s_cyc_o and s_stb_o SHALL be 0;
  - both stalls SHALL be 1;
  - in-flight transactions SHALL be abandoned, even mid-burst.
REQ-024 The first grant after reset release SHALL occur no earlier than the cycle after rst_i falls.

Verification
REQ-025 Drive ins_cyc/stb with adr 0x100; slave acks 1 cycle later with data 0xDEADBEEF -> owner=1 one cycle after request, s_adr_o=0x100, ins_ack_o=1 with ins_dat_o=0xDEADBEEF, dat_ack_o=0.
REQ-026 ins_cyc and dat_cyc rise in the same IDLE cycle -> owner=2, ins_stall_o=1 until dat cyc drops and its last ack returns, then owner=0 for one cycle, then owner=1.
REQ-027 ins issues 6 back-to-back strobes with slave ack withheld -> exactly 4 accepted, ins_stall_o=1 at outstanding=4; each later ack admits one more strobe.
REQ-028 Ack and new accepted strobe in the same cycle at outstanding=2 -> outstanding remains 2.
REQ-029 dat owner drops cyc with 2 outstanding while ins_cyc is high -> s_cyc_o stays 1, s_stb_o=0, 2 acks go to dat_ack_o, then IDLE, then owner=1.
REQ-030 Assert rst_i with owner=1 and outstanding=3 -> next cycle owner=0, outstanding=0, s_cyc_o=0, both stalls=1, and a stray s_ack_i produces no master ack.
